theta_row_sched: RTL and testbench



---
 rtl/theta_row_sched.sv | 200 ++++++++++++++++++++
 tb/tb_theta_row_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_row_sched.sv
// theta_row_sched: two-lane round-robin scheduler feeding one row-wide Whirlpool theta (MixRows).
// Build option THETA_ROW_SCHED_REG_EN registers the theta output and adds a DRAIN state.
module theta_mix_row (
    input  logic [63:0] i_row,
    output logic [63:0] o_row
);
    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Row times the circulant cir(01,01,04,01,08,05,02,09); byte 0 is the MSB.
    function automatic logic [63:0] mix_row(input logic [63:0] row);
        logic [7:0]  a  [8];
        logic [7:0]  x2 [8];
        logic [7:0]  x4 [8];
        logic [7:0]  x8 [8];
        logic [63:0] res;
        logic [2:0]  p;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            p     = 3'(i);
            a[p]  = row[{~p, 3'd0} +: 8];
            x2[p] = xtime(a[p]);
            x4[p] = xtime(x2[p]);
            x8[p] = xtime(x4[p]);
        end
        for (int j = 0; j < 8; j++) begin
            p = 3'(j);
            res[{~p, 3'd0} +: 8] = a[p] ^ a[p + 3'd7] ^ x4[p + 3'd6] ^ a[p + 3'd5]
                                 ^ x8[p + 3'd4] ^ x4[p + 3'd3] ^ a[p + 3'd3]
                                 ^ x2[p + 3'd2] ^ x8[p + 3'd1] ^ a[p + 3'd1];
        end
        return res;
    endfunction

    assign o_row = mix_row(i_row);
endmodule

module theta_row_sched (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_k,
    input  logic [511:0] k_in,
    output logic         gnt_k,
    output logic         done_k,
    output logic [511:0] k_out,
    input  logic         req_s,
    input  logic [511:0] s_in,
    output logic         gnt_s,
    output logic         done_s,
    output logic [511:0] s_out,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
`ifdef THETA_ROW_SCHED_REG_EN
        DRAIN,
`endif
        DONE
    } state_t;

    state_t       r_state;
    logic         r_rr;
    logic         r_owner;      // 0: K lane, 1: S lane
    logic [2:0]   r_row;
    logic [511:0] r_job;
    logic [511:0] r_res;
    logic [511:0] r_k_out;
    logic [511:0] r_s_out;
    logic         r_done_k;
    logic         r_done_s;
    logic         r_busy;

    logic         w_idle;
    logic         w_pick_k;
    logic         w_pick_s;
    logic [63:0]  w_feed_row;
    logic [63:0]  w_theta;
    logic         w_wr_en;
    logic [2:0]   w_wr_row;
    logic [63:0]  w_wr_data;
    logic         w_last;
    logic [511:0] w_res_next;

    assign w_idle   = (r_state == IDLE);
    assign w_pick_k = req_k & (~req_s | ~r_rr);
    assign w_pick_s = req_s & (~req_k |  r_rr);

    // NOTE: grants are decoded from IDLE so the lane's data is taken in the grant cycle itself;
    // reset_n gates them because a synchronous reset cannot clear a combinational output.
    assign gnt_k = reset_n & w_idle & w_pick_k;
    assign gnt_s = reset_n & w_idle & w_pick_s;

    // Row r occupies bits [511-64r -: 64]; for a 3-bit index, 7-r is simply ~r.
    assign w_feed_row = r_job[{~r_row, 6'd0} +: 64];

    theta_mix_row u_theta (
        .i_row (w_feed_row),
        .o_row (w_theta)
    );

`ifdef THETA_ROW_SCHED_REG_EN
    logic [63:0] r_pipe;
    logic [2:0]  r_pipe_row;
    logic        r_pipe_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pipe     <= '0;
            r_pipe_row <= '0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe     <= w_theta;
            r_pipe_row <= r_row;
            r_pipe_vld <= (r_state == RUN);
        end
    end

    assign w_wr_en   = r_pipe_vld;
    assign w_wr_row  = r_pipe_row;
    assign w_wr_data = r_pipe;
`else
    assign w_wr_en   = (r_state == RUN);
    assign w_wr_row  = r_row;
    assign w_wr_data = w_theta;
`endif

    assign w_last = w_wr_en & (w_wr_row == 3'd7);

    always_comb begin
        w_res_next = r_res;
        w_res_next[{~w_wr_row, 6'd0} +: 64] = w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_row    <= '0;
            r_job    <= '0;
            r_res    <= '0;
            r_k_out  <= '0;
            r_s_out  <= '0;
            r_done_k <= 1'b0;
            r_done_s <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done_k <= 1'b0;
            r_done_s <= 1'b0;
            if (w_wr_en) r_res <= w_res_next;
            case (r_state)
                IDLE: begin
                    if (gnt_k | gnt_s) begin
                        r_job   <= gnt_k ? k_in : s_in;
                        r_owner <= gnt_s;
                        r_rr    <= gnt_k;
                        r_row   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_row <= r_row + 3'd1;
`ifdef THETA_ROW_SCHED_REG_EN
                    if (r_row == 3'd7) r_state <= DRAIN;
`else
                    if (r_row == 3'd7) r_state <= DONE;
`endif
                end
`ifdef THETA_ROW_SCHED_REG_EN
                DRAIN: r_state <= DONE;
`endif
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // The last row write publishes the whole matrix, so done and data appear together.
            if (w_last) begin
                if (r_owner) begin
                    r_s_out  <= w_res_next;
                    r_done_s <= 1'b1;
                end else begin
                    r_k_out  <= w_res_next;
                    r_done_k <= 1'b1;
                end
            end
        end
    end

    assign k_out  = r_k_out;
    assign s_out  = r_s_out;
    assign done_k = r_done_k;
    assign done_s = r_done_s;
    assign busy   = r_busy;
endmodule

// File: tb/tb_theta_row_sched.sv
// Self-checking bench for theta_row_sched: directed scenarios plus randomized traffic against
// a transaction-level model (GF(2^8) matrix arithmetic and grant/done cycle arithmetic).
module tb_theta_row_sched;
    localparam logic [63:0] ROW_ONE = 64'h0100000000000000;
    localparam logic [63:0] ROW_MIX = 64'h0101040108050209;
`ifdef THETA_ROW_SCHED_REG_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic         clk = 1'b0;
    logic         reset_n, req_k, req_s;
    logic [511:0] k_in, s_in;
    logic         gnt_k, gnt_s, done_k, done_s, busy;
    logic [511:0] k_out, s_out;

    always #5 clk = ~clk;

    theta_row_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_k   (req_k),
        .k_in    (k_in),
        .gnt_k   (gnt_k),
        .done_k  (done_k),
        .k_out   (k_out),
        .req_s   (req_s),
        .s_in    (s_in),
        .gnt_s   (gnt_s),
        .done_s  (done_s),
        .s_out   (s_out),
        .busy    (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Driver values applied at the next falling edge.
    logic         drv_rn, drv_rk, drv_rs;
    logic [511:0] drv_dk, drv_ds;

    // Reference model state.
    bit           m_active, m_owner_s, m_rr;
    int           m_gnt_cyc, m_done_cyc;
    logic [511:0] m_res, m_k_out, m_s_out;
    bit           exp_gnt_k, exp_gnt_s;

    // Observed DUT events (used only for timing and event counts).
    bit obs_gnt_k, obs_gnt_s, obs_done_k, obs_done_s;
    int n_gnt_s, n_done_k, n_done_s;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [63:0] mix_row(input logic [63:0] row);
        logic [7:0]  c [8];
        logic [63:0] res;
        logic [7:0]  acc;
        c = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
        res = '0;
        for (int j = 0; j < 8; j++) begin
            acc = 8'h00;
            for (int i = 0; i < 8; i++) acc = acc ^ gmul(row[63-8*i -: 8], c[(j - i + 8) % 8]);
            res[63-8*j -: 8] = acc;
        end
        return res;
    endfunction

    function automatic logic [511:0] mix_mat(input logic [511:0] m);
        logic [511:0] res;
        res = '0;
        for (int r = 0; r < 8; r++) res[511-64*r -: 64] = mix_row(m[511-64*r -: 64]);
        return res;
    endfunction

    function automatic logic [511:0] rand_mat();
        logic [511:0] m;
        m = '0;
        case ($urandom_range(0, 3))
            0: m = '0;
            1: m[$urandom_range(0, 511)] = 1'b1;
            default: for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
        endcase
        return m;
    endfunction

    // One cycle of the reference model: expected outputs, compare, then state update.
    task automatic model_step();
        bit idle, ek, es, ebusy, edk, eds;
        if (m_active && cyc == m_done_cyc) begin
            if (m_owner_s) m_s_out = m_res;
            else           m_k_out = m_res;
        end
        idle  = !m_active || (cyc > m_done_cyc);
        ek    = 1'b0;
        es    = 1'b0;
        if (reset_n && idle) begin
            ek = req_k && (!req_s || !m_rr);
            es = req_s && (!req_k ||  m_rr);
        end
        ebusy = m_active && (cyc > m_gnt_cyc) && (cyc <= m_done_cyc);
        edk   = m_active && (cyc == m_done_cyc) && !m_owner_s;
        eds   = m_active && (cyc == m_done_cyc) &&  m_owner_s;
        check("gnt_k", gnt_k, ek);
        check("gnt_s", gnt_s, es);
        check("done_k", done_k, edk);
        check("done_s", done_s, eds);
        check("busy", busy, ebusy);
        check("k_out", k_out, m_k_out);
        check("s_out", s_out, m_s_out);
        exp_gnt_k = ek;
        exp_gnt_s = es;
        if (!reset_n) begin
            m_active = 1'b0;
            m_rr     = 1'b0;
            m_k_out  = '0;
            m_s_out  = '0;
        end else if (ek || es) begin
            m_active   = 1'b1;
            m_owner_s  = es;
            m_gnt_cyc  = cyc;
            m_done_cyc = cyc + LAT;
            m_res      = mix_mat(ek ? k_in : s_in);
            m_rr       = ek;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        reset_n = drv_rn;
        req_k   = drv_rk;
        k_in    = drv_dk;
        req_s   = drv_rs;
        s_in    = drv_ds;
        #1;
        cyc++;
        model_step();
        obs_gnt_k  = (gnt_k  === 1'b1);
        obs_gnt_s  = (gnt_s  === 1'b1);
        obs_done_k = (done_k === 1'b1);
        obs_done_s = (done_s === 1'b1);
        if (obs_gnt_s)  n_gnt_s++;
        if (obs_done_k) n_done_k++;
        if (obs_done_s) n_done_s++;
    endtask

    // Bounded wait: 0 gnt_k, 1 gnt_s, 2 done_k, 3 done_s, 4 any grant. at = -1 on timeout.
    task automatic wait_event(input int which, input int budget, output int at);
        bit hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            case (which)
                0: hit = obs_gnt_k;
                1: hit = obs_gnt_s;
                2: hit = obs_done_k;
                3: hit = obs_done_s;
                default: hit = obs_gnt_k | obs_gnt_s;
            endcase
            if (hit) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        int g, d, snap_k, snap_s, snap_g, rel;
        int at_q [4];
        bit lane_q [4];
        logic [511:0] data;

        reset_n = 1'b0; req_k = 1'b0; req_s = 1'b0; k_in = '0; s_in = '0;
        drv_rn = 1'b0; drv_rk = 1'b0; drv_rs = 1'b0; drv_dk = '0; drv_ds = '0;
        m_active = 1'b0; m_owner_s = 1'b0; m_rr = 1'b0;
        m_gnt_cyc = 0; m_done_cyc = 0; m_res = '0; m_k_out = '0; m_s_out = '0;
        n_gnt_s = 0; n_done_k = 0; n_done_s = 0;

        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_k_out", k_out, '0);

        // K alone with the reference vector.
        drv_rn = 1'b1;
        drv_rk = 1'b1;
        drv_dk = {ROW_ONE, 448'd0};
        snap_s = n_done_s;
        wait_event(0, 20, g);
        drv_rk = 1'b0;
        drv_dk = rand_mat();
        wait_event(2, 30, d);
        check("k1_latency", d - g, LAT);
        check("k1_row0", k_out[511:448], ROW_MIX);
        check("k1_rows1_7", k_out[447:0], 448'd0);
        check("k1_s_out", s_out, '0);
        check("k1_no_done_s", n_done_s - snap_s, 0);

        // Both lanes held from reset release: strict K,S,K,S alternation.
        drv_rn = 1'b0;
        drv_rk = 1'b1;
        drv_rs = 1'b1;
        tick();
        drv_rn = 1'b1;
        rel = cyc + 1;
        for (int n = 0; n < 4; n++) begin
            drv_dk = rand_mat();
            drv_ds = rand_mat();
            wait_event(4, 30, at_q[n]);
            lane_q[n] = obs_gnt_s;
        end
        drv_rk = 1'b0;
        drv_rs = 1'b0;
        check("rr_first_at", at_q[0], rel);
        for (int n = 0; n < 4; n++) begin
            check("rr_lane", lane_q[n], n % 2);
            if (n > 0) check("rr_gap", at_q[n] - at_q[n-1], LAT + 1);
        end
        wait_event(3, 30, d);

        // S lane: all rows set, then all zero.
        drv_rs = 1'b1;
        drv_ds = {8{ROW_ONE}};
        wait_event(1, 20, g);
        drv_rs = 1'b0;
        wait_event(3, 30, d);
        check("s_all_rows", s_out, {8{ROW_MIX}});
        drv_rs = 1'b1;
        drv_ds = '0;
        wait_event(1, 20, g);
        drv_rs = 1'b0;
        drv_ds = rand_mat();
        wait_event(3, 30, d);
        check("s_zero", s_out, '0);

        // Reset at T+4 of a K job.
        drv_rk = 1'b1;
        drv_dk = rand_mat();
        wait_event(0, 20, g);
        drv_rk = 1'b0;
        snap_k = n_done_k;
        while (cyc < g + 3) tick();
        drv_rn = 1'b0;
        tick();
        drv_rn = 1'b1;
        tick();
        check("abort_k_out", k_out, '0);
        check("abort_s_out", s_out, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", {done_k, done_s}, 2'b00);
        data   = rand_mat();
        drv_rs = 1'b1;
        drv_ds = data;
        wait_event(1, 20, g);
        drv_rs = 1'b0;
        drv_ds = rand_mat();
        wait_event(3, 30, d);
        check("abort_s_latency", d - g, LAT);
        check("abort_s_result", s_out, mix_mat(data));
        check("abort_no_done_k", n_done_k - snap_k, 0);

        // One-cycle S request during a busy K job is lost.
        data   = rand_mat();
        drv_rk = 1'b1;
        drv_dk = data;
        wait_event(0, 20, g);
        drv_rk = 1'b0;
        snap_g = n_gnt_s;
        snap_s = n_done_s;
        tick();
        tick();
        drv_rs = 1'b1;
        drv_ds = rand_mat();
        tick();
        drv_rs = 1'b0;
        wait_event(2, 30, d);
        for (int i = 0; i < 12; i++) tick();
        check("pulse_no_gnt_s", n_gnt_s - snap_g, 0);
        check("pulse_no_done_s", n_done_s - snap_s, 0);
        check("pulse_k_result", k_out, mix_mat(data));

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            drv_rn = ($urandom_range(0, 499) != 0);
            if (exp_gnt_k || (drv_rk && $urandom_range(0, 15) == 0)) drv_rk = 1'b0;
            else if (!drv_rk && $urandom_range(0, 2) == 0)            drv_rk = 1'b1;
            if (exp_gnt_s || (drv_rs && $urandom_range(0, 15) == 0)) drv_rs = 1'b0;
            else if (!drv_rs && $urandom_range(0, 2) == 0)            drv_rs = 1'b1;
            drv_dk = rand_mat();
            drv_ds = rand_mat();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
